// File: rtl/mem_sequencer_pkg.sv
// Shared definitions for the memory sequencer: widths, bus command and FSM
// encodings, the LED/SW peripheral addresses and the address-class legality rule.
package mem_sequencer_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 2;

  localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
  localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CLS_RAM      = 2'b00,
    CLS_LED      = 2'b01,
    CLS_SW       = 2'b10,
    CLS_UNMAPPED = 2'b11
  } addr_class_e;

  // RAM is read/write, LED write-only, SW read-only, anything else rejected.
  function automatic logic access_legal(addr_class_e cls, logic is_write);
    case (cls)
      CLS_RAM: return 1'b1;
      CLS_LED: return is_write;
      CLS_SW:  return !is_write;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_sequencer_if.sv
// Requester + memory bus bundle for mem_sequencer.
//   slave  : sequencer view (takes requests, drives responses and the bus)
//   master : environment view (issues requests, returns read_data)
interface mem_sequencer_if;
  import mem_sequencer_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  mem_cmd_e          mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, read_data,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_cmd, mem_addr, write_data
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, read_data,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_cmd, mem_addr, write_data
  );

endinterface

// File: rtl/mem_sequencer_addr_decode.sv
// Combinational address classifier (mem_addr_decode).
//   addr_i       : transaction address
//   addr_class_o : RAM / LED / SW / UNMAPPED
module mem_addr_decode
  import mem_sequencer_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output addr_class_e       addr_class_o
);

  always_comb begin
    addr_class_o = CLS_UNMAPPED;
    if (!addr_i[ADDR_W-1]) begin
      addr_class_o = CLS_RAM;
    end else if (addr_i == LED_ADDR) begin
      addr_class_o = CLS_LED;
    end else if (addr_i == SW_ADDR) begin
      addr_class_o = CLS_SW;
    end
  end

endmodule

// File: rtl/mem_sequencer.sv
// Single-outstanding memory sequencer: accepts one load/store, runs it on the
// memory bus (RAM, LED, SW), and returns a one-cycle completion pulse.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : request/response handshake and memory bus (slave modport)
module mem_sequencer
  import mem_sequencer_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_sequencer_if.slave  bus
);

  state_e            state_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  mem_cmd_e          mem_cmd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] write_data_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  addr_class_e       req_class;
  logic              req_legal;

  mem_addr_decode u_decode (
    .addr_i       (bus.req_addr),
    .addr_class_o (req_class)
  );

  assign req_legal = access_legal(req_class, bus.req_write);

  // Ready is the only combinational output; gated by reset so it drops at once.
  assign bus.req_ready  = (state_q == ST_IDLE) && !reset;
  assign bus.mem_cmd    = mem_cmd_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.write_data = write_data_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_rdata  = rsp_rdata_q;

  // Sequencer FSM; the bus address/data registers double as the request latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rd_cnt_q     <= '0;
      mem_cmd_q    <= CMD_NONE;
      mem_addr_q   <= '0;
      write_data_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (!req_legal) begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (bus.req_write) begin
              state_q      <= ST_WR;
              mem_cmd_q    <= CMD_WRITE;
              mem_addr_q   <= bus.req_addr;
              write_data_q <= bus.req_wdata;
            end else begin
              state_q    <= ST_RD;
              mem_cmd_q  <= CMD_READ;
              mem_addr_q <= bus.req_addr;
              rd_cnt_q   <= '0;
            end
          end
        end
        ST_RD: begin
          // READ_LATENCY+1 RD cycles; capture on the edge that ends the last one.
          if (rd_cnt_q == CNT_W'(READ_LATENCY)) begin
            state_q     <= ST_DONE;
            mem_cmd_q   <= CMD_NONE;
            rsp_rdata_q <= bus.read_data;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
          end else begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
          end
        end
        ST_WR: begin
          state_q     <= ST_DONE;
          mem_cmd_q   <= CMD_NONE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_cmd_q <= CMD_NONE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameter READ_LATENCY, default 1, SHALL set the number of cycles between a RAM address being presented and read_data being valid; legal range is 1..3.
REQ-002 clk  input  1  rising-edge system clock, the only clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  requester presents a transaction.
REQ-005 req_ready  output  1  sequencer accepts a transaction this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  9  transaction address.
REQ-008 req_wdata  input  16  store data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_err  output  1  completion was rejected; qualified by rsp_valid.
REQ-011 rsp_rdata  output  16  load result; qualified by rsp_valid with rsp_err=0.
REQ-012 mem_cmd  output  2  bus command: 00 NONE, 01 READ, 10 WRITE; 11 is never driven.
REQ-013 mem_addr  output  9  bus address.
REQ-014 write_data  output  16  bus store data.
REQ-015 read_data  input  16  bus load data.

Function
REQ-016 The address map SHALL be: addr[8]=0 is RAM (read/write); 9'h100 is LED (write-only); 9'h140 is SW (read-only); every other address is unmapped.
REQ-017 A transaction SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-018 At acceptance, req_write, req_addr and req_wdata SHALL be latched, so later changes to the inputs have no effect.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 The FSM states SHALL be IDLE, RD, WR and DONE.
REQ-021 IDLE SHALL transition: to RD on an accepted legal load; to WR on an accepted legal store; to DONE on an accepted illegal access.
REQ-022 RD SHALL be held for READ_LATENCY+1 cycles with mem_cmd=READ and mem_addr equal to the latched address.
REQ-023 read_data SHALL be captured into rsp_rdata on the edge that ends the last RD cycle, and the FSM SHALL then go to DONE.
REQ-024 WR SHALL last exactly one cycle with mem_cmd=WRITE, mem_addr equal to the latched address and write_data equal to the latched data, then go to DONE.
REQ-025 DONE SHALL assert rsp_valid for exactly one cycle and then return to IDLE.
REQ-026 Latency, counted from the acceptance edge to the rsp_valid cycle, SHALL be: load READ_LATENCY+2 cycles; store 2 cycles; error 1 cycle.
REQ-027 Illegal accesses SHALL set rsp_err=1, leave mem_cmd=NONE throughout, and leave rsp_rdata unchanged. Illegal accesses are: a store to SW, a load from LED, and any unmapped address.
REQ-028 A legal completion SHALL set rsp_err=0.
REQ-029 A store SHALL leave rsp_rdata unchanged.
REQ-030 mem_cmd SHALL be NONE in IDLE and DONE.
REQ-031 mem_addr and write_data SHALL hold their last driven values between transactions.
REQ-032 The maximum back-to-back rate SHALL be one new acceptance in the cycle after DONE; req_valid held high SHALL be accepted immediately.
REQ-033 All outputs except req_ready SHALL be driven directly from registers.

Reset
REQ-034 While reset=1 the sequencer SHALL force: state IDLE, mem_cmd=00, mem_addr=0, write_data=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0.
REQ-035 An assertion of reset during RD or WR SHALL discard the transaction, drive mem_cmd=NONE without waiting for a clock edge, and never produce an rsp_valid for that transaction.
REQ-036 On the first rising edge after reset is released, the sequencer SHALL be able to accept a request (req_ready=1).

Structure
REQ-037 A shared package SHALL hold the mem_cmd encodings (NONE/READ/WRITE), the LED address 9'h100, the SW address 9'h140, and the FSM state encodings.
REQ-038 One combinational sub-module, mem_addr_decode, SHALL classify an address as RAM, LED, SW or UNMAPPED.
REQ-039 The legality check SHALL combine the mem_addr_decode class with the request direction.

Verification
REQ-040 Bench scenario, RAM load: load addr 9'h005 with the RAM model returning 16'hBEEF, READ_LATENCY=1 -> mem_cmd=01 for 2 cycles at addr 005, then rsp_valid 3 cycles after acceptance with rsp_rdata=BEEF and rsp_err=0.
REQ-041 Bench scenario, LED store: store 16'h00A5 to 9'h100 -> mem_cmd=10 for exactly 1 cycle with mem_addr=100 and write_data=00A5, then rsp_valid on the next cycle with rsp_err=0.
REQ-042 Bench scenario, illegal accesses: store to 9'h140, load from 9'h100, and load from 9'h1FF -> each gives mem_cmd=00 throughout, rsp_valid 1 cycle after acceptance with rsp_err=1, and rsp_rdata unchanged.
REQ-043 Bench scenario, back-to-back: req_valid held high for load 9'h010 then store to 9'h011 -> second acceptance occurs in the cycle after the first DONE, and the second request's fields are not sampled early.
REQ-044 Bench scenario, reset mid-read: assert reset in the second RD cycle -> mem_cmd=00 before the next edge, no rsp_valid, and req_ready=1 on the first edge after release.
REQ-045 Bench scenario, latency sweep: repeat REQ-040 with READ_LATENCY=3 -> rsp_valid exactly 5 cycles after acceptance, with read_data sampled only on the final RD edge.
